// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared mode/state types and default screen size for the draw engine
package draw_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    FILL_ROM   = 2'd0,
    RECT_SOLID = 2'd1,
    RECT_ROM   = 2'd2,
    NOP        = 2'd3
  } draw_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } draw_state_t;

endpackage

// File: rtl/draw_cmd_if.sv
// rtl/draw_cmd_if.sv - command channel into the draw engine
interface draw_cmd_if import draw_pkg::*; #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int DW = 6
);

  logic          cmd_valid;
  logic          cmd_ready;
  draw_mode_t    cmd_mode;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [DW-1:0] cmd_w;
  logic [DW-1:0] cmd_h;
  logic [CW-1:0] cmd_color;

  modport master (
    output cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready
  );

endinterface

// File: rtl/draw_raster_counter.sv
// rtl/draw_raster_counter.sv - row-major col/row scan with a linear address and last-pixel flag
module draw_raster_counter #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic row_end;

  assign row_end = (col == w - XW'(1));
  assign last    = row_end && (row == h - YW'(1));

  // Wraps back to zero after the last pixel so the next command starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      if (last) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (row_end) begin
        col  <= '0;
        row  <= row + YW'(1);
        addr <= addr + AW'(1);
      end else begin
        col  <= col + XW'(1);
        addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/draw_engine.sv
// rtl/draw_engine.sv - command-driven pixel plotter: fill, solid rect and ROM sprite with clipping/key
module draw_engine import draw_pkg::*; #(
  parameter int             SCREEN_W  = SCREEN_W_DEF,
  parameter int             SCREEN_H  = SCREEN_H_DEF,
  parameter int             XW        = 8,
  parameter int             YW        = 7,
  parameter int             CW        = 3,
  parameter int             DW        = 6,
  parameter int             AW        = 15,
  parameter bit             KEY_EN    = 1'b1,
  parameter logic [CW-1:0]  KEY_COLOR = '0
) (
  input  logic          clk,
  input  logic          reset,
  draw_cmd_if.slave     cmd,
  output logic [AW-1:0] rom_addr,
  input  logic [CW-1:0] rom_data,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] color,
  output logic          writeEn,
  output logic          busy,
  output logic          done
);

  localparam logic [XW:0] SW_LIM = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] SH_LIM = (YW+1)'(SCREEN_H);

  draw_state_t   state;
  draw_mode_t    mode_l;
  draw_mode_t    s1_mode;
  logic [XW-1:0] org_x;
  logic [YW-1:0] org_y;
  logic [XW-1:0] w_l;
  logic [YW-1:0] h_l;
  logic [CW-1:0] color_l;
  logic          ready_q;
  logic          drain_cnt;
  logic [DW-1:0] w_in;
  logic [DW-1:0] h_in;
  logic          run;

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          last;
  logic [XW:0]   px;
  logic [YW:0]   py;

  logic          s1_valid;
  logic          s1_clip;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic          keyed;

  assign w_in          = cmd.cmd_w;
  assign h_in          = cmd.cmd_h;
  assign run           = (state == RUN);
  assign cmd.cmd_ready = ready_q;
  assign busy          = !ready_q;

  draw_raster_counter #(
    .XW (XW),
    .YW (YW),
    .AW (AW)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .w     (w_l),
    .h     (h_l),
    .col   (col),
    .row   (row),
    .addr  (rom_addr),
    .last  (last)
  );

  // One extra bit so off-screen pixels compare as clipped instead of wrapping.
  assign px = {1'b0, org_x} + {1'b0, col};
  assign py = {1'b0, org_y} + {1'b0, row};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
      mode_l    <= NOP;
      org_x     <= '0;
      org_y     <= '0;
      w_l       <= '0;
      h_l       <= '0;
      color_l   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            ready_q   <= 1'b0;
            mode_l    <= cmd.cmd_mode;
            color_l   <= cmd.cmd_color;
            drain_cnt <= 1'b0;
            if (cmd.cmd_mode == FILL_ROM) begin
              org_x <= '0;
              org_y <= '0;
              w_l   <= XW'(SCREEN_W);
              h_l   <= YW'(SCREEN_H);
              state <= RUN;
            end else begin
              org_x <= cmd.cmd_x;
              org_y <= cmd.cmd_y;
              w_l   <= XW'(w_in);
              h_l   <= YW'(h_in);
              if (cmd.cmd_mode == NOP || w_in == '0 || h_in == '0)
                state <= DRAIN;
              else
                state <= RUN;
            end
          end
        end
        RUN: begin
          if (last) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done    <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rom_data arrives one cycle after rom_addr, alongside stage-1 coordinates.
  assign keyed = KEY_EN && (s1_mode == RECT_ROM) && (rom_data == KEY_COLOR);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_clip  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_mode  <= NOP;
      writeEn  <= 1'b0;
      x        <= '0;
      y        <= '0;
      color    <= '0;
    end else begin
      s1_valid <= run;
      s1_clip  <= (px >= SW_LIM) || (py >= SH_LIM);
      s1_x     <= px[XW-1:0];
      s1_y     <= py[YW-1:0];
      s1_mode  <= mode_l;
      writeEn  <= s1_valid && !s1_clip && !keyed;
      x        <= s1_x;
      y        <= s1_y;
      color    <= (s1_mode == RECT_SOLID) ? color_l : rom_data;
    end
  end

endmodule

// File: tb/tb_draw_engine.sv
// tb/tb_draw_engine.sv - directed self-checking bench for draw_engine
module tb_draw_engine;
  import draw_pkg::*;

  logic        clk;
  logic        reset;
  logic [14:0] rom_addr;
  logic [2:0]  rom_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        writeEn;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int rom_pat = 0;

  int n_writes, done_cyc, model_err, reacc_cyc, corner_color, first_we, last_we;
  int busy_c1, rdy_after;

  draw_cmd_if #(.XW(8), .YW(7), .CW(3), .DW(6)) cmd_bus ();

  draw_engine dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd_bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .color    (color),
    .writeEn  (writeEn),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] rom_f(input logic [14:0] a);
    logic [2:0] v;
    case (rom_pat)
      0:       v = a[2:0];
      1:       v = {2'b00, a[0]};
      default: v = a[2:0] | 3'b100;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic run_cmd(input draw_mode_t m, input int ox, input int oy, input int w, input int h,
                         input int col, input int max_cyc, input int hold, input int reset_at);
    int k, xx, yy, addr, npix, wd, oxi, oyi;
    logic [2:0] rv, exp_col;
    logic exp_we;
    n_writes = 0; done_cyc = -1; model_err = 0; reacc_cyc = -1; corner_color = -1;
    first_we = -1; last_we = -1; busy_c1 = -1; rdy_after = -1;
    cmd_bus.cmd_mode  = m;
    cmd_bus.cmd_x     = 8'(ox);
    cmd_bus.cmd_y     = 7'(oy);
    cmd_bus.cmd_w     = 6'(w);
    cmd_bus.cmd_h     = 6'(h);
    cmd_bus.cmd_color = 3'(col);
    cmd_bus.cmd_valid = 1'b1;
    if (m == FILL_ROM) begin
      wd = 160; oxi = 0; oyi = 0; npix = 19200;
    end else begin
      wd = w; oxi = ox; oyi = oy; npix = (m == NOP) ? 0 : w * h;
    end
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 1 && hold == 0) cmd_bus.cmd_valid = 1'b0;
      if (reset_at > 0 && c == reset_at) reset = 1'b1;
      if (reset_at > 0 && c == reset_at + 1) begin
        reset = 1'b0;
        rdy_after = int'(cmd_bus.cmd_ready);
      end
      k = c - 3;
      exp_we = 1'b0; exp_col = 3'd0; xx = 0; yy = 0;
      if (k >= 0 && k < npix && (reset_at == 0 || c <= reset_at)) begin
        xx = oxi + k % wd;
        yy = oyi + k / wd;
        addr = (m == FILL_ROM) ? yy * 160 + xx : k;
        rv = rom_f(15'(addr));
        exp_col = (m == RECT_SOLID) ? 3'(col) : rv;
        exp_we = (xx < 160) && (yy < 120) && !(m == RECT_ROM && rv == 3'd0);
      end
      if (writeEn !== exp_we) model_err++;
      else if (exp_we && (x !== 8'(xx) || y !== 7'(yy) || color !== exp_col)) model_err++;
      if (writeEn === 1'b1) begin
        n_writes++;
        if (first_we < 0) first_we = c;
        last_we = c;
        if (x == 8'd159 && y == 7'd119) corner_color = int'(color);
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c == 1) busy_c1 = int'(busy);
      if (cmd_bus.cmd_valid && cmd_bus.cmd_ready && reacc_cyc < 0) reacc_cyc = c;
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_mode  = NOP;
    cmd_bus.cmd_x     = '0;
    cmd_bus.cmd_y     = '0;
    cmd_bus.cmd_w     = '0;
    cmd_bus.cmd_h     = '0;
    cmd_bus.cmd_color = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_writeEn", writeEn, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_color", color, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_bus.cmd_ready, 1);

    run_cmd(RECT_SOLID, 10, 20, 3, 2, 5, 11, 0, 0);
    chk("solid_busy_c1", busy_c1, 1);
    chk("solid_writes", n_writes, 6);
    chk("solid_first", first_we, 3);
    chk("solid_last", last_we, 8);
    chk("solid_done", done_cyc, 9);
    chk("solid_model", model_err, 0);

    rom_pat = 0;
    run_cmd(FILL_ROM, 0, 0, 0, 0, 0, 19205, 0, 0);
    chk("fill_writes", n_writes, 19200);
    chk("fill_corner", corner_color, 7);
    chk("fill_done", done_cyc, 19203);
    chk("fill_model", model_err, 0);

    rom_pat = 2;
    run_cmd(RECT_ROM, 158, 118, 4, 4, 0, 21, 0, 0);
    chk("clip_writes", n_writes, 4);
    chk("clip_corner", corner_color, 5);
    chk("clip_done", done_cyc, 19);
    chk("clip_model", model_err, 0);

    rom_pat = 1;
    run_cmd(RECT_ROM, 20, 30, 8, 8, 0, 67, 1, 0);
    chk("key_writes", n_writes, 32);
    chk("key_done", done_cyc, 67);
    chk("key_reaccept", reacc_cyc, 67);
    chk("key_model", model_err, 0);
    do_reset();

    run_cmd(RECT_SOLID, 40, 50, 8, 8, 3, 12, 0, 5);
    chk("rstmid_writes", n_writes, 3);
    chk("rstmid_done", done_cyc, -1);
    chk("rstmid_ready", rdy_after, 1);
    chk("rstmid_model", model_err, 0);

    run_cmd(NOP, 5, 5, 4, 4, 2, 6, 0, 0);
    chk("nop_writes", n_writes, 0);
    chk("nop_done", done_cyc, 3);

    run_cmd(RECT_SOLID, 5, 5, 0, 4, 2, 6, 0, 0);
    chk("w0_writes", n_writes, 0);
    chk("w0_done", done_cyc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_engine.md
# draw_engine

Command-driven pixel plotter for the 160x120 VGA adapter path. It is the parametrised successor to the game datapath's hand-coded fill and square loops. One accepted command paints one of three things: a full-screen picture from ROM, a solid rectangle, or a ROM-sourced sprite rectangle. Painting runs at one pixel per clock, in raster order, with screen-edge clipping and an optional transparent colour key. Its outputs drive the VGA adapter's `x`/`y`/`color`/`writeEn` inputs directly.

## Interface
Parameters:
- `SCREEN_W`, 160: visible width in pixels.
- `SCREEN_H`, 120: visible height in pixels.
- `XW`, 8: x coordinate width.
- `YW`, 7: y coordinate width.
- `CW`, 3: colour width.
- `DW`, 6: rectangle dimension width; maximum rectangle side is 2^DW-1.
- `AW`, 15: ROM address width; must satisfy 2^AW ≥ SCREEN_W*SCREEN_H.
- `KEY_EN`, 1: enable the transparent colour key in RECT_ROM mode.
- `KEY_COLOR`, 0: colour value treated as transparent.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_mode` in 2: 0 FILL_ROM, 1 RECT_SOLID, 2 RECT_ROM, 3 NOP.
- `cmd_x` in XW, `cmd_y` in YW: rectangle origin (top-left).
- `cmd_w` in DW, `cmd_h` in DW: rectangle width and height in pixels.
- `cmd_color` in CW: fill colour for RECT_SOLID.
- `rom_addr` out AW: picture/sprite ROM address; the ROM is registered with 1-cycle read latency.
- `rom_data` in CW: ROM read data.
- `x` out XW, `y` out YW, `color` out CW, `writeEn` out 1: VGA plot port.
- `busy` out 1: equals `!cmd_ready`.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - RUN: one address per cycle.
  - DRAIN: 2 cycles while the pipeline empties.
  - IDLE again, with `done` pulsed for 1 cycle.
- Command fields are latched on acceptance. `cmd_valid` while busy is ignored, not queued.
- FILL_ROM:
  - Origin is (0,0) and size is SCREEN_W x SCREEN_H; `cmd_x/y/w/h/color` are ignored.
  - `rom_addr` = y*SCREEN_W + x, generated incrementally (no multiplier).
  - The colour key is not applied.
- RECT_SOLID: `color` = latched `cmd_color`; `rom_addr` is don't-care.
- RECT_ROM:
  - `rom_addr` = row*w + col, a linear counter starting at 0.
  - When `KEY_EN` is set and `rom_data`==KEY_COLOR, that pixel's `writeEn`=0.
- NOP, or `cmd_w`==0, or `cmd_h`==0: no RUN cycles and no `writeEn`; `done` still pulses.
- Scan order is row-major: col 0..w-1 within each row, rows 0..h-1.
- Screen coordinates are computed at XW+1 / YW+1 bits. A pixel with x ≥ SCREEN_W or y ≥ SCREEN_H is clipped:
  - it still occupies its cycle slot;
  - `writeEn`=0 for that slot;
  - coordinates never wrap.
- `x`/`y`/`color` are meaningful only when `writeEn`=1.

## Timing
- Acceptance edge = cycle 0. For N pixels:
  - `rom_addr` for pixel k is presented at cycle 1+k.
  - Pixel k appears on `x`/`y`/`color`/`writeEn` at cycle 3+k (fixed 2-cycle latency, all modes).
  - `done`=1 and `cmd_ready`=1 at cycle N+3; a new command can be accepted at that edge.
- Zero-pixel command: `done` at cycle 3.
- Throughput: 1 pixel/clock. A full-screen FILL takes 19200+3 cycles.
- Reset values:
  - `x`, `y`, `color`, `writeEn`, `done`, `busy`, `rom_addr` = 0.
  - `cmd_ready`=1 from the first cycle after reset.
- Reset mid-command:
  - the next cycle is IDLE and the pipeline is flushed;
  - no further `writeEn` and no `done`.

## Structure
- `draw_pkg` holds:
  - the `draw_mode_t` enum (FILL_ROM, RECT_SOLID, RECT_ROM, NOP);
  - the `draw_state_t` enum (IDLE, RUN, DRAIN);
  - the default screen constants 160/120.
- One sub-module, `draw_raster_counter`:
  - inputs: width and height;
  - outputs: col, row, linear address, and last-pixel flag;
  - the top-level uses it for both FILL and RECT address generation.
- The top level holds:
  - the FSM;
  - command latches;
  - the 2-stage coordinate/mode pipeline aligned with ROM latency;
  - clip and key logic.

## Test plan
- RECT_SOLID x=10, y=20, w=3, h=2, color=5:
  - exactly 6 `writeEn` pulses at cycles 3..8, at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all color 5;
  - `done` at cycle 9.
- FILL_ROM with ROM data = addr[2:0]:
  - 19200 writes;
  - pixel (159,119) has color = 19199 mod 8 = 7;
  - `done` at cycle 19203.
- RECT_ROM x=158, y=118, w=4, h=4:
  - only (158,118),(159,118),(158,119),(159,119) are written;
  - clipped slots have `writeEn`=0;
  - `done` at cycle 19.
- RECT_ROM 8x8 with KEY_EN=1, where ROM returns 0 at even addresses:
  - exactly 32 writes;
  - `cmd_valid` held high throughout is accepted only once, at cycle 0 and not again until cycle 67.
- Reset asserted at cycle 5 of an 8x8 RECT_SOLID:
  - `writeEn`=0 from cycle 6 onward;
  - no `done`;
  - `cmd_ready`=1 at cycle 6.
- NOP and w=0 commands: zero writes, `done` at cycle 3.
